sram_bank_requester: RTL and testbench

- Initiator side of the single-port banked SRAM interface (A/CEB/WEB/D/Q, active-low enables, 1-cycle read latency).
- Accepts read/write requests on a valid/ready port and drives the memory pins.
- Captures read data one cycle after issue into a response FIFO.
- Presents read data in request order on a valid/ready response port, with credit-based flow control so no read data is ever dropped.

---
 rtl/sram_req_pkg.sv | 32 +++
 rtl/sram_rsp_fifo.sv | 71 +++++++
 rtl/sram_bank_requester.sv | 136 +++++++++++++
 tb/tb_sram_bank_requester.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_req_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_req_pkg
// Description : Shared definitions for the banked-SRAM requester: default
//               widths, FSM state encoding, request record and a pointer
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_req_pkg;

  // 6x1024-word bank: 13 address bits, upper bits select the macro.
  localparam int c_addr_width = 13;
  localparam int c_data_width = 16;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,   // power-on clear sweep (only with SRAM_INIT_EN)
    ST_RUN  = 1'b1    // normal request service
  } state_t;

  typedef struct packed {
    logic                    write;
    logic [c_addr_width-1:0] addr;
    logic [c_data_width-1:0] data;
  } req_t;

  // Pointer width for an N-entry ring; a 1-entry ring still needs one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : sram_req_pkg
`default_nettype wire

// File: rtl/sram_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sram_rsp_fifo
// Description : Circular response FIFO, DEPTH entries of WIDTH bits.
//               head_data is the oldest entry and stays put until popped.
// Ports       : CLK, RST (async, active high)
//               push/push_data  - write a new entry at the tail
//               pop             - retire the head entry (ignored when empty)
//               head_data       - oldest entry
//               count           - occupancy 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module sram_rsp_fifo
  import sram_req_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int c_ptr_w = ptr_width(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH+1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_cnt_w-1:0] r_count;
  logic               w_do_pop;
  logic               w_full;

  function automatic logic [c_ptr_w-1:0] wrap_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign w_do_pop  = pop && (r_count != '0);
  assign w_full    = (r_count == c_cnt_w'(DEPTH));
  assign head_data = r_mem[r_head];
  assign count     = r_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (push)     r_tail <= wrap_inc(r_tail);
      if (w_do_pop) r_head <= wrap_inc(r_head);
      if (push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (push) r_mem[r_tail] <= push_data;
  end

  // Credit accounting upstream guarantees a free slot for every push
  // unless the head leaves in the same cycle.
  a_no_overflow : assert property (@(posedge CLK) disable iff (RST)
                                   !(push && w_full && !w_do_pop));

endmodule : sram_rsp_fifo
`default_nettype wire

// File: rtl/sram_bank_requester.sv
`default_nettype none
// ============================================================================
// Module      : sram_bank_requester
// Description : Initiator for a single-port banked SRAM (A/CEB/WEB/D/Q,
//               active-low enables, 1-cycle read latency). Requests enter on
//               a valid/ready port, read data returns in issue order on a
//               valid/ready response port. Reads are only issued when a
//               response slot is guaranteed, so read data is never dropped.
// Build macro : SRAM_INIT_EN - power-on sweep writing zero to every address
//               before requests are accepted (init_busy high meanwhile).
// Ports       : CLK, RST (async, active high)
//               req_valid/req_ready/req_write/req_addr/req_data - requests
//               rsp_valid/rsp_ready/rsp_data                    - read data
//               mem_A/mem_CEB/mem_WEB/mem_D/mem_Q               - SRAM pins
//               init_busy                                       - sweep active
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bank_requester
  import sram_req_pkg::*;
#(
  parameter int ADDR_WIDTH = c_addr_width,
  parameter int DATA_WIDTH = c_data_width,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] mem_A,
  output logic                  mem_CEB,
  output logic                  mem_WEB,
  output logic [DATA_WIDTH-1:0] mem_D,
  input  logic [DATA_WIDTH-1:0] mem_Q,
  output logic                  init_busy
);

  localparam int c_cnt_w = $clog2(RSP_DEPTH+1);

  state_t                r_state;
  logic                  r_rd_pending;
  logic [c_cnt_w-1:0]    w_fifo_count;
  logic                  w_run;
  logic                  w_credit_ok;
  logic                  w_fire;
  logic                  w_init_active;
  logic [ADDR_WIDTH-1:0] w_init_addr;

`ifdef SRAM_INIT_EN
  logic [ADDR_WIDTH-1:0] r_init_addr;

  // Sweep one address per cycle; leave INIT after the all-ones address.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= ST_INIT;
      r_init_addr <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_addr <= r_init_addr + 1'b1;
          if (&r_init_addr) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign w_init_active = (r_state == ST_INIT) && !RST;
  assign w_init_addr   = r_init_addr;
  assign init_busy     = (r_state == ST_INIT);
`else
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= ST_RUN;
    else     r_state <= ST_RUN;
  end

  assign w_init_active = 1'b0;
  assign w_init_addr   = '0;
  assign init_busy     = 1'b0;
`endif

  // RST gates the combinational pin path so the memory sees an idle,
  // zeroed interface for the whole reset window.
  assign w_run = (r_state == ST_RUN) && !RST;

  // A read needs a slot for itself on top of everything already owed.
  // A same-cycle pop is deliberately not counted as a freed slot.
  assign w_credit_ok = (int'(w_fifo_count) + int'(r_rd_pending)) < RSP_DEPTH;
  assign req_ready   = w_run && (req_write || w_credit_ok);
  assign w_fire      = req_valid && req_ready;

  always_comb begin
    mem_CEB = 1'b1;
    mem_WEB = 1'b1;
    mem_A   = '0;
    mem_D   = '0;
    if (w_run) begin
      mem_CEB = ~w_fire;
      mem_WEB = ~(w_fire && req_write);
      mem_A   = req_addr;
      mem_D   = req_data;
    end else if (w_init_active) begin
      mem_CEB = 1'b0;
      mem_WEB = 1'b0;
      mem_A   = w_init_addr;
    end
  end

  // mem_Q is valid the cycle after the read edge; this flag marks it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_rd_pending <= 1'b0;
    else     r_rd_pending <= w_fire && !req_write;
  end

  sram_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (r_rd_pending),
    .push_data (mem_Q),
    .pop       (rsp_valid && rsp_ready),
    .head_data (rsp_data),
    .count     (w_fifo_count)
  );

  assign rsp_valid = (w_fifo_count != '0);

endmodule : sram_bank_requester
`default_nettype wire

// File: tb/tb_sram_bank_requester.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sram_bank_requester
// Description : Self-checking bench for sram_bank_requester with a simple
//               single-port SRAM model on the memory pins. Read expectations
//               are queued at acceptance and compared on each response
//               handshake. With SRAM_INIT_EN the DUT uses a 4-bit address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bank_requester;

`ifdef SRAM_INIT_EN
  localparam int AW = 4;
`else
  localparam int AW = 13;
`endif
  localparam int DW    = 16;
  localparam int DEPTH = 2;

  localparam int A_M0_I = (AW > 4) ? 'h400 : 4;
  localparam int A_M1_I = (AW > 4) ? 'h800 : 8;
  localparam logic [AW-1:0] A_LO  = AW'(5);
  localparam logic [AW-1:0] A_M0  = AW'(A_M0_I);
  localparam logic [AW-1:0] A_M1  = AW'(A_M1_I);
  localparam logic [AW-1:0] A_TOP = {AW{1'b1}};

  logic          CLK = 1'b0;
  logic          RST;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] mem_A;
  logic          mem_CEB, mem_WEB;
  logic [DW-1:0] mem_D, mem_Q;
  logic          init_busy;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] sb[$];

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs[$];

  always #5 CLK = ~CLK;

  sram_bank_requester #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RSP_DEPTH  (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .mem_A     (mem_A),
    .mem_CEB   (mem_CEB),
    .mem_WEB   (mem_WEB),
    .mem_D     (mem_D),
    .mem_Q     (mem_Q),
    .init_busy (init_busy)
  );

  // Single-port SRAM, 1-cycle read latency; preset to a non-zero pattern.
  logic [DW-1:0] sram [2**AW];
  logic [DW-1:0] q_r;
  initial for (int i = 0; i < 2**AW; i++) sram[i] = 16'hDEAD;
  always @(posedge CLK) begin
    if (!mem_CEB) begin
      if (!mem_WEB) sram[mem_A] <= mem_D;
      else          q_r <= sram[mem_A];
    end
  end
  assign mem_Q = q_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Response scoreboard: every handshake must match the oldest expectation.
  always @(negedge CLK) begin
    if (!RST && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got %0h want none", rsp_data);
      end else begin
        check("rsp_data", 32'(rsp_data), 32'(sb.pop_front()));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic issue(input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] e);
    int n;
    bit done;
    n = 0;
    done = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_data  = d;
    while (!done) begin
      @(negedge CLK);
      if (req_ready) begin
        done = 1;
        check("pin_ceb",  32'(mem_CEB), 32'd0);
        check("pin_web",  32'(mem_WEB), 32'(!wr));
        check("pin_addr", 32'(mem_A),   32'(a));
        if (wr) check("pin_d", 32'(mem_D), 32'(d));
        else    sb.push_back(e);
      end else if (++n > 40) begin
        done = 1;
        total++;
        bad++;
        $display("FAIL req_timeout: got no accept want accept for addr %0h", a);
      end
      @(posedge CLK);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{1'b1, A_LO,  16'hBEEF, 16'h0000});
    vecs.push_back('{1'b0, A_LO,  16'h0000, 16'hBEEF});
    vecs.push_back('{1'b1, A_M0,  16'h1111, 16'h0000});
    vecs.push_back('{1'b1, A_M1,  16'h2222, 16'h0000});
    vecs.push_back('{1'b0, A_M0,  16'h0000, 16'h1111});
    vecs.push_back('{1'b0, A_M1,  16'h0000, 16'h2222});
    vecs.push_back('{1'b1, A_TOP, 16'h5A5A, 16'h0000});
    vecs.push_back('{1'b0, A_TOP, 16'h0000, 16'h5A5A});
    vecs.push_back('{1'b0, A_M1,  16'h0000, 16'h2222});
`ifdef SRAM_INIT_EN
    vecs.push_back('{1'b0, AW'(3), 16'h0000, 16'h0000});
`endif

    // Reset with a read request present: nothing may reach the memory.
    RST = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = A_LO;
    req_data  = 16'h1234;
    rsp_ready = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_ceb",   32'(mem_CEB),   32'd1);
    check("rst_web",   32'(mem_WEB),   32'd1);
    check("rst_addr",  32'(mem_A),     32'd0);
    check("rst_d",     32'(mem_D),     32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
`ifndef SRAM_INIT_EN
    check("rst_busy",  32'(init_busy), 32'd0);
    req_valid = 1'b0;
`endif
    @(posedge CLK);
    #1;
    RST = 1'b0;

`ifdef SRAM_INIT_EN
    // Sweep: one zero-write per cycle, requests held off throughout.
    begin
      int n;
      n = 0;
      @(negedge CLK);
      while (init_busy && n < 100) begin
        check("init_ready", 32'(req_ready), 32'd0);
        check("init_ceb",   32'(mem_CEB),   32'd0);
        check("init_web",   32'(mem_WEB),   32'd0);
        check("init_addr",  32'(mem_A),     32'(n));
        n++;
        @(negedge CLK);
      end
      req_valid = 1'b0;
      check("init_len", 32'(n), 32'(2**AW));
      @(posedge CLK);
      #1;
    end
`endif
    idle(2);

    // Table: writes, reads, read-after-write, across macros.
    foreach (vecs[i]) issue(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp);
    idle(5);

    // Read latency into an empty FIFO is exactly two cycles.
    issue(1'b0, A_LO, 16'h0, 16'hBEEF);
    @(negedge CLK);
    check("lat_n1_valid", 32'(rsp_valid), 32'd0);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check("lat_n2_valid", 32'(rsp_valid), 32'd1);
    check("lat_n2_data",  32'(rsp_data),  32'hBEEF);
    idle(4);

    // Back-to-back reads to different macros give consecutive responses.
    issue(1'b0, A_M0, 16'h0, 16'h1111);
    issue(1'b0, A_M1, 16'h0, 16'h2222);
    @(negedge CLK);
    check("b2b_v1", 32'(rsp_valid), 32'd1);
    check("b2b_d1", 32'(rsp_data),  32'h1111);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check("b2b_v2", 32'(rsp_valid), 32'd1);
    check("b2b_d2", 32'(rsp_data),  32'h2222);
    idle(4);

    // Credit stall: consumer blocked, third read waits for a pop.
    rsp_ready = 1'b0;
    issue(1'b0, A_LO, 16'h0, 16'hBEEF);
    issue(1'b0, A_M0, 16'h0, 16'h1111);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = A_M1;
    @(negedge CLK);
    check("stall_a", 32'(req_ready), 32'd0);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check("stall_b",    32'(req_ready), 32'd0);
    check("hold_valid", 32'(rsp_valid), 32'd1);
    check("hold_data",  32'(rsp_data),  32'hBEEF);
    @(posedge CLK);
    #1;
    rsp_ready = 1'b1;
    @(negedge CLK);
    check("stall_pop", 32'(req_ready), 32'd0);
    @(posedge CLK);
    #1;
    rsp_ready = 1'b0;
    @(negedge CLK);
    check("stall_accept", 32'(req_ready), 32'd1);
    if (req_ready) sb.push_back(16'h2222);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    idle(6);
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Reset while a read is in flight: the response must vanish.
    issue(1'b0, A_LO, 16'h0, 16'hBEEF);
    RST = 1'b1;
    sb.delete();
    @(negedge CLK);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("post_rst_valid", 32'(rsp_valid), 32'd0);
`ifdef SRAM_INIT_EN
      check("post_rst_busy", 32'(init_busy), 32'd1);
`else
      check("post_rst_ceb", 32'(mem_CEB), 32'd1);
`endif
    end
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sram_bank_requester
`default_nettype wire
